// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: repeat FSM encoding and
// default cycle counts (auto-repeat enabled by defining BTN_AUTOREPEAT_EN).
package btn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_e;

  localparam int DEF_NB_BTN          = 3;
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_REPEAT_DELAY    = 50_000_000;
  localparam int DEF_REPEAT_PERIOD   = 10_000_000;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchronizer, counter debouncer and registered press
// pulse; with BTN_AUTOREPEAT_EN defined a hold/repeat FSM adds repeat pulses.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef BTN_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic btn_i,
  output logic level_o,
  output logic pulse_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q;

  // Count consecutive cycles the synchronized input disagrees with the
  // accepted level; any agreement restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) level_d = sync2_q;
      else                   cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  rpt_state_e       state_q;
  logic [RPT_W-1:0] rpt_cnt_q;

  // A falling level always returns to IDLE, even on a coincident terminal count.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      rpt_cnt_q <= '0;
      pulse_q   <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          rpt_cnt_q <= '0;
          if (level_d && !level_q) begin
            pulse_q <= 1'b1;
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!level_d) begin
            state_q   <= ST_IDLE;
            rpt_cnt_q <= '0;
          end else if (rpt_cnt_q == DELAY_LAST) begin
            pulse_q   <= 1'b1;
            rpt_cnt_q <= '0;
            state_q   <= ST_REPEAT;
          end else begin
            rpt_cnt_q <= rpt_cnt_q + 1'b1;
          end
        end
        ST_REPEAT: begin
          if (!level_d) begin
            state_q   <= ST_IDLE;
            rpt_cnt_q <= '0;
          end else if (rpt_cnt_q == PERIOD_LAST) begin
            pulse_q   <= 1'b1;
            rpt_cnt_q <= '0;
          end else begin
            rpt_cnt_q <= rpt_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          rpt_cnt_q <= '0;
        end
      endcase
    end
  end
`else
  always_ff @(posedge i_clk) begin
    if (i_reset) pulse_q <= 1'b0;
    else         pulse_q <= level_d & ~level_q;
  end
`endif

  assign level_o = level_q;
  assign pulse_o = pulse_q;

endmodule

// File: rtl/btn_conditioner.sv
// Conditions NB_BTN raw push-buttons into debounced levels and one-cycle press
// pulses. Define BTN_AUTOREPEAT_EN to add hold-to-repeat pulses.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int NB_BTN          = DEF_NB_BTN,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NB_BTN-1:0] i_btn,
  output logic [NB_BTN-1:0] o_btn_level,
  output logic [NB_BTN-1:0] o_btn_pulse
);

  if (NB_BTN < 1) begin : g_bad_nb
    $error("btn_conditioner: NB_BTN must be >= 1");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
    $error("btn_conditioner: DEBOUNCE_CYCLES must be >= 1");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_rpt
    $error("btn_conditioner: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  for (genvar g = 0; g < NB_BTN; g++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef BTN_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
    ) u_ch (
      .i_clk  (i_clk),
      .i_reset(i_reset),
      .btn_i  (i_btn[g]),
      .level_o(o_btn_level[g]),
      .pulse_o(o_btn_pulse[g])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Randomized and directed bench for btn_conditioner against a window-based
// reference model of the synchronizer, debouncer and press/repeat pulses.
module tb_btn_conditioner;

  localparam int NB = 3;
  localparam int DC = 4;
  localparam int RD = 8;
  localparam int RP = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] btn = '0;
  logic [NB-1:0] lvl, pls;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  btn_conditioner #(
    .NB_BTN(NB), .DEBOUNCE_CYCLES(DC), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_btn(btn),
    .o_btn_level(lvl), .o_btn_pulse(pls)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: level flips once the last DC post-sync samples all
  // disagree with it; post-sync sample at an edge is the raw input two edges earlier.
  logic [15:0]   hist [NB];
  logic [NB-1:0] m_level = '0;
  logic [NB-1:0] m_pulse = '0;
  int            held [NB];
  logic          want, flip, prev;

  always @(posedge clk) begin
    cyc++;
    for (int c = 0; c < NB; c++) begin
      if (rst) begin
        hist[c]    = '0;
        m_level[c] = 1'b0;
        m_pulse[c] = 1'b0;
        held[c]    = 0;
      end else begin
        want = ~m_level[c];
        flip = 1'b1;
        for (int j = 1; j <= DC; j++) if (hist[c][j] != want) flip = 1'b0;
        prev = m_level[c];
        if (flip) m_level[c] = want;
`ifdef BTN_AUTOREPEAT_EN
        if (m_level[c] && !prev) held[c] = 0;
        else                     held[c]++;
        m_pulse[c] = m_level[c] && (held[c] == 0 || held[c] == RD ||
                                    (held[c] > RD && (held[c] - RD) % RP == 0));
`else
        m_pulse[c] = m_level[c] & ~prev;
`endif
        hist[c] = {hist[c][14:0], btn[c]};
      end
    end
  end

  // Per-cycle comparison plus a log of pulse cycles for the directed checks.
  int plog [NB][$];
  always @(negedge clk) begin
    if (chk_en) begin
      chk("level", {29'd0, lvl}, {29'd0, m_level});
      chk("pulse", {29'd0, pls}, {29'd0, m_pulse});
    end
    for (int c = 0; c < NB; c++) if (pls[c] === 1'b1) plog[c].push_back(cyc);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int k, b0, b1, b2, run [NB];

  initial begin
    rst = 1'b1;
    btn = '0;
    step(3);
    chk_en = 1'b1;
    chk("reset_level", {29'd0, lvl}, 32'd0);
    chk("reset_pulse", {29'd0, pls}, 32'd0);
    rst = 1'b0;
    step(2);

    // Clean press on channel 0
    b0 = plog[0].size();
    btn[0] = 1'b1;
    k = cyc + 1;
    step(20);
    btn[0] = 1'b0;
    step(12);
    chk("clean_first_pulse", plog[0][b0], k + 5);
`ifdef BTN_AUTOREPEAT_EN
    chk("clean_pulse_count", plog[0].size() - b0, 5);
`else
    chk("clean_pulse_count", plog[0].size() - b0, 1);
`endif

    // Bounce on channel 1: 1,0,1,1,0 then held high
    b1 = plog[1].size();
    k = cyc + 1;
    btn[1] = 1'b1; step(1);
    btn[1] = 1'b0; step(1);
    btn[1] = 1'b1; step(2);
    btn[1] = 1'b0; step(1);
    btn[1] = 1'b1; step(15);
    btn[1] = 1'b0; step(12);
    chk("bounce_first_pulse", plog[1][b1], k + 10);
`ifndef BTN_AUTOREPEAT_EN
    chk("bounce_pulse_count", plog[1].size() - b1, 1);
`endif

    // Simultaneous press on all channels
    b0 = plog[0].size(); b1 = plog[1].size(); b2 = plog[2].size();
    btn = 3'b111;
    k = cyc + 1;
    step(7);
    btn = 3'b000;
    step(12);
    chk("simul_pulse0", plog[0][b0], k + 5);
    chk("simul_pulse1", plog[1][b1], k + 5);
    chk("simul_pulse2", plog[2][b2], k + 5);

    // Reset while channel 0 debounce count is 2, button held through reset
    b0 = plog[0].size();
    btn[0] = 1'b1;
    k = cyc + 1;
    step(4);
    rst = 1'b1;
    step(1);
    chk("midreset_level", {29'd0, lvl}, 32'd0);
    chk("midreset_pulse", {29'd0, pls}, 32'd0);
    rst = 1'b0;
    step(9);
    btn[0] = 1'b0;
    step(12);
    chk("midreset_pulse_cycle", plog[0][b0], k + 10);
`ifndef BTN_AUTOREPEAT_EN
    chk("midreset_pulse_count", plog[0].size() - b0, 1);
`endif

    // Short glitch on channel 2 must be rejected
    b2 = plog[2].size();
    btn[2] = 1'b1; step(3);
    btn[2] = 1'b0; step(12);
    chk("glitch_pulse_count", plog[2].size() - b2, 0);

`ifdef BTN_AUTOREPEAT_EN
    // Hold channel 0 for 30 cycles: press, +8, then every 3
    b0 = plog[0].size();
    btn[0] = 1'b1;
    k = cyc + 1;
    step(30);
    btn[0] = 1'b0;
    step(15);
    chk("rpt_pulse_count", plog[0].size() - b0, 9);
    chk("rpt_first", plog[0][b0], k + 5);
    chk("rpt_second", plog[0][b0 + 1], k + 13);
    chk("rpt_third", plog[0][b0 + 2], k + 16);
`endif

    // Random run lengths per channel with occasional resets
    for (int c = 0; c < NB; c++) run[c] = 0;
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < NB; c++) begin
        if (run[c] == 0) begin
          btn[c] = $urandom_range(0, 1);
          run[c] = $urandom_range(1, 12);
        end
        run[c]--;
      end
      rst = ($urandom_range(0, 199) == 0);
      step(1);
    end
    rst = 1'b0;
    btn = '0;
    step(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
